// File: rtl/im_loader.sv
`default_nettype none
// ============================================================================
// Module   : im_loader
// Brief    : Loads a program image, one 32-bit word per valid/ready
//            handshake, into the instruction memory write port. Holds the CPU
//            until the image is complete and reports the image end PC.
//            Optional macro IM_LOADER_CHECKSUM_EN: the final (in_last) word is
//            a 32-bit wrapping checksum of the written words and is not
//            itself written.
// Revision : 1.0 - initial release
// ============================================================================
module im_loader #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold,
    output logic [ADDR_W:0]   word_count,
    output logic [31:0]       end_pc
);

    // word_count doubles as the write pointer; it is one bit wider than the
    // address so that a completely full memory is representable.
    localparam logic [ADDR_W:0] c_capacity  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] c_last_slot = {1'b0, {ADDR_W{1'b1}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            w_xfer;
    logic            w_write;
    logic            w_clear;
    logic [ADDR_W:0] w_count_inc;

`ifdef IM_LOADER_CHECKSUM_EN
    logic [31:0]     r_sum;
`endif

    assign w_xfer      = in_valid && in_ready;
    assign w_count_inc = word_count + 1'b1;

    // Next-state and write decision from current state and handshake
    always_comb begin
        w_next  = r_state;
        w_write = 1'b0;
        w_clear = 1'b0;
        case (r_state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    w_next  = LOAD;
                    w_clear = 1'b1;
                end
            end
            LOAD: begin
                if (w_xfer) begin
`ifdef IM_LOADER_CHECKSUM_EN
                    // Checksum word is compared, never written
                    if (in_last) begin
                        w_next = (r_sum == in_data) ? DONE : ERR;
                    end else if (word_count == c_capacity) begin
                        w_next = ERR;
                    end else begin
                        w_write = 1'b1;
                    end
`else
                    w_write = 1'b1;
                    if (in_last) begin
                        w_next = DONE;
                    end else if (word_count == c_last_slot) begin
                        // Last slot filled but image continues: overflow
                        w_next = ERR;
                    end
`endif
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // State register, registered status outputs and IM write port
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            cpu_hold   <= 1'b1;
            we         <= 1'b0;
            waddr      <= '0;
            wdata      <= '0;
            word_count <= '0;
            end_pc     <= BASE_ADDR;
        end else begin
            r_state  <= w_next;
            // Status flags follow the state being entered so they are
            // registered yet exactly aligned with the state.
            in_ready <= (w_next == LOAD);
            busy     <= (w_next == LOAD);
            done     <= (w_next == DONE);
            err      <= (w_next == ERR);
            cpu_hold <= (w_next != DONE);
            we       <= w_write;
            if (w_clear) begin
                word_count <= '0;
                end_pc     <= BASE_ADDR;
            end
            if (w_write) begin
                waddr      <= word_count[ADDR_W-1:0];
                wdata      <= in_data;
                word_count <= w_count_inc;
                end_pc     <= BASE_ADDR + (32'(w_count_inc) << 2);
            end
        end
    end

`ifdef IM_LOADER_CHECKSUM_EN
    // Running 32-bit wrapping sum of the words actually written
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sum <= '0;
        end else if (w_clear) begin
            r_sum <= '0;
        end else if (w_write) begin
            r_sum <= r_sum + in_data;
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/im_loader.md
Name: im_loader

Overview:
- Writer-side counterpart of the instruction fetch path: loads a program image, one 32-bit word per handshake, into the instruction memory that the IFU later reads.
- Holds the CPU (cpu_hold) until the image is complete.
- Reports the image end PC so the bench/CPU knows the program extent.
- Sits between a host/bench word source and the IM write port of the single-cycle CPU.

Parameters:
ADDR_W, 10, IM word-address width; capacity 2^ADDR_W words
BASE_ADDR, 32'h0000_3000, byte PC of IM word 0

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset (reset==0 at a clk edge resets)
start  input  1  begin a new load; sampled only in IDLE, DONE, ERR
in_valid  input  1  source has a word on in_data
in_data  input  32  program word
in_last  input  1  qualifies the final word of the image
in_ready  output  1  loader accepts a word this cycle
we  output  1  IM write enable, one-cycle pulse per word
waddr  output  ADDR_W  IM word address for the write
wdata  output  32  IM write data
busy  output  1  state==LOAD
done  output  1  image loaded successfully
err  output  1  overflow (or checksum failure, see Optional Feature)
cpu_hold  output  1  keep CPU/IFU in reset while 1
word_count  output  ADDR_W+1  words written in current/last load
end_pc  output  32  BASE_ADDR + 4*word_count, valid when done==1

Behaviour:
- All outputs registered or Moore (decoded from state only); no input-to-output combinational path.
- Reset (reset==0 at edge): state IDLE; in_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0, err=0, cpu_hold=1, word_count=0, end_pc=BASE_ADDR. Reset wins over every other input; a reset mid-LOAD abandons the load with no further we pulses.
- FSM states: IDLE, LOAD, DONE, ERR.
- IDLE: in_ready=0. start=1 -> LOAD; on that edge pointer and word_count cleared, done/err cleared, cpu_hold=1.
- LOAD: in_ready=1, busy=1.
- Transfer = in_valid && in_ready at a clk edge.
- On a transfer, on the next cycle: we=1, waddr=pointer, wdata=in_data. Pointer and word_count increment. Write latency is exactly 1 cycle.
- Between transfers we=0; waddr/wdata hold their last values.
- Transfer with in_last=1 -> DONE next cycle; that word is still written.
- Capacity: a transfer at pointer==2^ADDR_W-1 with in_last=0 writes the word, then -> ERR (err=1).
- A transfer at pointer==2^ADDR_W-1 with in_last=1 -> DONE (exactly full is legal). The pointer never wraps.
- start asserted during LOAD is ignored.
- in_valid outside LOAD is ignored; in_ready is 0 there.
- DONE: done=1, cpu_hold=0, busy=0, in_ready=0; end_pc = BASE_ADDR + (word_count<<2) in 32-bit arithmetic. start=1 -> LOAD with the same clearing as from IDLE; cpu_hold returns to 1 on that edge.
- ERR: err=1, done=0, cpu_hold=1. Exits only via start (-> LOAD) or reset.
- Empty image is impossible: at least one word (the in_last word) is always required.

Optional Feature:
- Macro: IM_LOADER_CHECKSUM_EN.
- Defined:
  - The in_last word is a checksum and is NOT written (no we pulse for it; word_count excludes it).
  - Loader keeps a 32-bit wrapping sum of all written words, cleared on start.
  - On the in_last transfer: sum==in_data -> DONE, otherwise -> ERR.
  - Capacity rule counts written words only. A transfer at pointer==2^ADDR_W with in_last=0 -> ERR without a write.
- Not defined: in_last word is an ordinary program word, written as above; no sum logic is synthesized.

Test Plan:
- Reset: hold reset=0 for 2 cycles with start=1, in_valid=1 -> all outputs at reset values, cpu_hold=1, in_ready=0, no we.
- Basic load: start, then 3 words 0x3C010001, 0x34210002, 0x00000000 (last) with in_valid held high -> we pulses at waddr 0,1,2 with matching wdata, each one cycle after its transfer; done=1, cpu_hold=0, word_count=3, end_pc=0x0000300C.
- Backpressure/gaps: in_valid toggled 1,0,0,1,1(last) -> exactly 3 writes at consecutive addresses; no we in the gap cycles; start pulsed mid-load has no effect.
- Overflow (ADDR_W=2): 5 words, none last -> 4 writes (addr 0..3), err=1, cpu_hold=1, done=0; then start -> LOAD with word_count=0, err=0.
- Exact fill (ADDR_W=2): 4 words, 4th last -> done=1, word_count=4, end_pc=0x00003010.
- Reset mid-load after 2 words -> IDLE next cycle, no further we, word_count=0.
- With IM_LOADER_CHECKSUM_EN: words 1, 2, then checksum 3 (last) -> 2 writes, done=1. Repeat with checksum 4 -> err=1.
